// File: rtl/simple_ifetch.sv
// simple_ifetch: instruction-fetch stage of the SIMPLE pipeline.
// Owns the PC, issues reads to a 1-cycle-latency synchronous instruction RAM
// and fills the IF/ID register. A single-entry skid buffer catches the word
// that lands while decode is stalled, so no fetched instruction is lost.
module simple_ifetch #(
    parameter int                    PC_WIDTH    = 16,
    parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0,
    parameter logic [15:0]           BUBBLE_INST = 16'h0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run_en,
    input  logic                stall,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    input  logic                halt_dec,
    output logic [PC_WIDTH-1:0] imem_addr,
    output logic                imem_rd,
    input  logic [15:0]         imem_q,
    output logic [15:0]         if_inst,
    output logic [PC_WIDTH-1:0] if_pc_plus1,
    output logic                if_valid,
    output logic [PC_WIDTH-1:0] pc,
    output logic                halted
);

    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    logic                pend;
    logic [PC_WIDTH-1:0] pend_pc;
    logic [15:0]         skid;
    logic [PC_WIDTH-1:0] skid_pc;
    logic                skid_v;
    logic                issue;

    // A read may only start when nothing upstream or downstream blocks fetch.
    // Reset is included so no read is reported while the block is held in reset.
    always_comb begin
        issue     = run_en & ~stall & ~halted & ~redirect & ~halt_dec & ~reset;
        imem_rd   = issue;
        imem_addr = pc;
    end

    // PC, in-flight tracking, skid buffer and IF/ID register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            pend        <= 1'b0;
            pend_pc     <= '0;
            skid        <= '0;
            skid_pc     <= '0;
            skid_v      <= 1'b0;
            if_inst     <= BUBBLE_INST;
            if_pc_plus1 <= '0;
            if_valid    <= 1'b0;
            halted      <= 1'b0;
        end else if (redirect) begin
            // Wrong-path work is dropped, including a wrong-path HLT.
            pc       <= redirect_pc;
            pend     <= 1'b0;
            skid_v   <= 1'b0;
            if_inst  <= BUBBLE_INST;
            if_valid <= 1'b0;
            halted   <= 1'b0;
        end else if (halt_dec) begin
            // HLT takes precedence over a simultaneous stall hold.
            halted   <= 1'b1;
            pend     <= 1'b0;
            skid_v   <= 1'b0;
            if_inst  <= BUBBLE_INST;
            if_valid <= 1'b0;
        end else if (stall) begin
            // IF/ID holds; the word arriving now would be lost from the RAM
            // port, so park it. Clearing pend keeps it from being captured twice.
            if (pend) begin
                skid    <= imem_q;
                skid_pc <= pend_pc;
                skid_v  <= 1'b1;
                pend    <= 1'b0;
            end
        end else begin
            if (skid_v) begin
                if_inst     <= skid;
                if_pc_plus1 <= skid_pc + PC_ONE;
                if_valid    <= 1'b1;
                skid_v      <= 1'b0;
            end else if (pend) begin
                if_inst     <= imem_q;
                if_pc_plus1 <= pend_pc + PC_ONE;
                if_valid    <= 1'b1;
            end else begin
                if_inst  <= BUBBLE_INST;
                if_valid <= 1'b0;
            end
            // A new read may start in the same cycle the skid drains; its data
            // lands one cycle later, behind the skid word, so order is kept.
            pend <= issue;
            if (issue) begin
                pend_pc <= pc;
                pc      <= pc + PC_ONE;
            end
        end
    end

endmodule
